// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the asynchronous SRAM bus controller.
package sram_bus_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int DEF_READ_WAIT = 2;
    localparam int DEF_WRITE_PULSE = 2;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        RMW_RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        ACK,
        RECOVER
    } state_t;

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// CPU-side request/response bus of the SRAM controller.
interface sram_bus_ctrl_if;

    logic        cpu_sel;
    logic        cpu_rd_ena;
    logic        cpu_wr_ena;
    logic [1:0]  cpu_byte_ena;
    logic [31:0] cpu_address;
    logic [15:0] cpu_wr_data;
    logic [15:0] cpu_rd_data;
    logic        cpu_data_ack;

    modport master (
        output cpu_sel, cpu_rd_ena, cpu_wr_ena, cpu_byte_ena, cpu_address, cpu_wr_data,
        input  cpu_rd_data, cpu_data_ack
    );

    modport slave (
        input  cpu_sel, cpu_rd_ena, cpu_wr_ena, cpu_byte_ena, cpu_address, cpu_wr_data,
        output cpu_rd_data, cpu_data_ack
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the read-wait and write-pulse phases.
module sram_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Loading N-1 on phase entry makes done rise in the Nth cycle of the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// CPU to asynchronous 16-bit SRAM controller with read-modify-write for byte lanes.
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int READ_WAIT   = DEF_READ_WAIT,
    parameter int WRITE_PULSE = DEF_WRITE_PULSE
) (
    input  logic               clk,
    input  logic               rst,
    sram_bus_ctrl_if.slave     cpu,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_data_o,
    input  logic [SRAM_DW-1:0] sram_data_i,
    output logic               sram_data_oe,
    output logic               sram_cs_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    state_t state;
    state_t next_state;

    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;

    logic cs_n_d;
    logic oe_n_d;
    logic we_n_d;
    logic data_oe_d;
    logic ack_d;

    logic [1:0]         be_q;
    logic [SRAM_DW-1:0] rd_data_q;
    logic               ack_q;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{cpu.cpu_address[31:19], cpu.cpu_address[0]};

    sram_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .load_value(cnt_value),
        .done      (cnt_done)
    );

    // Strobes are decoded from next_state so they can be registered and
    // line up exactly with the state they belong to.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_value  = '0;
        case (state)
            IDLE: begin
                if (cpu.cpu_sel && (cpu.cpu_rd_ena || cpu.cpu_wr_ena)) begin
                    accept = 1'b1;
                    if (cpu.cpu_wr_ena) begin
                        if (cpu.cpu_byte_ena == 2'b00) begin
                            next_state = ACK;
                        end else if (cpu.cpu_byte_ena == 2'b11) begin
                            next_state = WR_SETUP;
                        end else begin
                            next_state = RMW_RD;
                            cnt_load   = 1'b1;
                            cnt_value  = CNT_W'(READ_WAIT - 1);
                        end
                    end else begin
                        next_state = RD_ACT;
                        cnt_load   = 1'b1;
                        cnt_value  = CNT_W'(READ_WAIT - 1);
                    end
                end
            end
            RD_ACT, RMW_RD: begin
                if (cnt_done) begin
                    next_state = (state == RD_ACT) ? ACK : WR_SETUP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR_SETUP: begin
                next_state = WR_PULSE;
                cnt_load   = 1'b1;
                cnt_value  = CNT_W'(WRITE_PULSE - 1);
            end
            WR_PULSE: begin
                if (cnt_done) begin
                    next_state = WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR_HOLD: next_state = ACK;
            ACK:     next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase

        cs_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
        ack_d     = 1'b0;
        case (next_state)
            RD_ACT, RMW_RD: begin
                cs_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            WR_SETUP: cs_n_d = 1'b0;
            WR_PULSE: begin
                cs_n_d    = 1'b0;
                we_n_d    = 1'b0;
                data_oe_d = 1'b1;
            end
            WR_HOLD: begin
                cs_n_d    = 1'b0;
                data_oe_d = 1'b1;
            end
            ACK:     ack_d = 1'b1;
            default: ;
        endcase
    end

    // The write-data register doubles as the merge target for partial writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sram_cs_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_data_oe <= 1'b0;
            ack_q        <= 1'b0;
            rd_data_q    <= '0;
            sram_addr    <= '0;
            sram_data_o  <= '0;
            be_q         <= '0;
        end else begin
            state        <= next_state;
            sram_cs_n    <= cs_n_d;
            sram_oe_n    <= oe_n_d;
            sram_we_n    <= we_n_d;
            sram_data_oe <= data_oe_d;
            ack_q        <= ack_d;
            if (accept) begin
                sram_addr <= cpu.cpu_address[SRAM_AW:1];
                be_q      <= cpu.cpu_byte_ena;
                if (cpu.cpu_wr_ena) begin
                    sram_data_o <= cpu.cpu_wr_data;
                end
            end
            if ((state == RD_ACT) && cnt_done) begin
                rd_data_q <= sram_data_i;
            end
            if ((state == RMW_RD) && cnt_done) begin
                sram_data_o <= {be_q[1] ? sram_data_o[15:8] : sram_data_i[15:8],
                                be_q[0] ? sram_data_o[7:0]  : sram_data_i[7:0]};
            end
        end
    end

    assign cpu.cpu_rd_data  = rd_data_q;
    assign cpu.cpu_data_ack = ack_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl with a behavioural SRAM and a scoreboard queue.
module tb_sram_bus_ctrl;
    import sram_bus_pkg::*;

    localparam int RW = 2;
    localparam int WP = 2;

    typedef struct packed {
        logic [7:0]  ack_cycle;
        logic        ack_next;
        logic [7:0]  cs_cycles;
        logic [7:0]  we_cycles;
        logic [15:0] rd_data;
        logic [15:0] word;
    } result_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [31:0] addr;
        logic [15:0] data;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_data_o;
    logic [SRAM_DW-1:0] sram_data_i;
    logic sram_data_oe, sram_cs_n, sram_oe_n, sram_we_n;

    logic [15:0] mem     [0:(1<<SRAM_AW)-1];
    logic [15:0] ref_mem [0:(1<<SRAM_AW)-1];
    logic        preload_en = 1'b0;
    logic [17:0] preload_addr = '0;
    logic [15:0] preload_data = '0;
    logic [15:0] model_rd;

    result_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cs_low_cnt = 0;
    int we_low_cnt = 0;
    int contention_cnt = 0;

    always #10 clk = ~clk;

    sram_bus_ctrl_if cpu_if();

    sram_bus_ctrl #(
        .READ_WAIT  (RW),
        .WRITE_PULSE(WP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu_if),
        .sram_addr   (sram_addr),
        .sram_data_o (sram_data_o),
        .sram_data_i (sram_data_i),
        .sram_data_oe(sram_data_oe),
        .sram_cs_n   (sram_cs_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    // Asynchronous SRAM: reads are combinational while selected, writes land on each we_n-low edge.
    assign sram_data_i = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

    always @(posedge clk) begin
        if (preload_en) mem[preload_addr] <= preload_data;
        else if (!sram_cs_n && !sram_we_n) mem[sram_addr] <= sram_data_o;
    end

    always @(negedge clk) begin
        if (!sram_cs_n) cs_low_cnt++;
        if (!sram_we_n) we_low_cnt++;
        if (sram_data_oe && !sram_oe_n) contention_cnt++;
    end

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        preload_en = 1'b1;
        preload_addr = a;
        preload_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    // Pushes the expected result, drives one request and measures what the DUT did.
    task automatic run_txn(input stim_t s, output result_t obs);
        result_t e;
        logic [17:0] w;
        logic [15:0] nw;
        int n;
        w = s.addr[18:1];
        e = '0;
        if (s.wr) begin
            if (s.be == 2'b00) begin
                e.ack_cycle = 8'd1;
            end else begin
                nw = ref_mem[w];
                if (s.be[1]) nw[15:8] = s.data[15:8];
                if (s.be[0]) nw[7:0] = s.data[7:0];
                ref_mem[w] = nw;
                e.ack_cycle = (s.be == 2'b11) ? 8'(WP + 3) : 8'(RW + WP + 3);
                e.cs_cycles = (s.be == 2'b11) ? 8'(WP + 2) : 8'(RW + WP + 2);
                e.we_cycles = 8'(WP);
            end
        end else begin
            e.ack_cycle = 8'(RW + 1);
            e.cs_cycles = 8'(RW);
            model_rd = ref_mem[w];
        end
        e.rd_data = model_rd;
        e.word = ref_mem[w];
        exp_q.push_back(e);

        @(negedge clk);
        cpu_if.cpu_sel = 1'b1;
        cpu_if.cpu_rd_ena = s.rd;
        cpu_if.cpu_wr_ena = s.wr;
        cpu_if.cpu_byte_ena = s.be;
        cpu_if.cpu_address = s.addr;
        cpu_if.cpu_wr_data = s.data;
        cs_low_cnt = 0;
        we_low_cnt = 0;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_if.cpu_data_ack && n < 40);
        obs = '0;
        obs.ack_cycle = cpu_if.cpu_data_ack ? 8'(n) : 8'hFF;
        obs.rd_data = cpu_if.cpu_rd_data;
        cpu_if.cpu_sel = 1'b0;
        cpu_if.cpu_rd_ena = 1'b0;
        cpu_if.cpu_wr_ena = 1'b0;
        cpu_if.cpu_wr_data = 16'hFFFF;
        @(negedge clk);
        obs.ack_next = cpu_if.cpu_data_ack;
        obs.cs_cycles = 8'(cs_low_cnt);
        obs.we_cycles = 8'(we_low_cnt);
        obs.word = mem[w];
    endtask

    task automatic test_reset();
        logic [54:0] got;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got = {sram_cs_n, sram_oe_n, sram_we_n, sram_data_oe, cpu_if.cpu_data_ack,
               cpu_if.cpu_rd_data, sram_addr, sram_data_o};
        n_checks++;
        if (got !== {5'b11100, 16'h0000, 18'h0, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got cs/oe/we/doe/ack=%b rd=%h addr=%h do=%h, expected 11100 rd=0000 addr=00000 do=0000",
                     got[54:50], got[49:34], got[33:16], got[15:0]);
        end
        model_rd = 16'h0000;
    endtask

    task automatic test_word_write_read();
        stim_t tbl[3];
        result_t obs, exp;
        tbl[0] = '{rd: 1'b0, wr: 1'b1, be: 2'b11, addr: 32'h0000_0100, data: 16'hA55A};
        tbl[1] = '{rd: 1'b1, wr: 1'b0, be: 2'b00, addr: 32'h0000_0100, data: 16'h0000};
        tbl[2] = '{rd: 1'b1, wr: 1'b0, be: 2'b01, addr: 32'hFFF8_0101, data: 16'h1111};
        foreach (tbl[i]) begin
            run_txn(tbl[i], obs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL word_rw[%0d]: got ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h, expected ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h",
                         i, obs.ack_cycle, obs.ack_next, obs.cs_cycles, obs.we_cycles, obs.rd_data, obs.word,
                         exp.ack_cycle, exp.ack_next, exp.cs_cycles, exp.we_cycles, exp.rd_data, exp.word);
            end
        end
    endtask

    task automatic test_byte_merge();
        stim_t tbl[2];
        result_t obs, exp;
        preload(18'h00100, 16'h1234);
        tbl[0] = '{rd: 1'b0, wr: 1'b1, be: 2'b10, addr: 32'h0000_0200, data: 16'hAB00};
        tbl[1] = '{rd: 1'b0, wr: 1'b1, be: 2'b01, addr: 32'h0000_0200, data: 16'h00CD};
        foreach (tbl[i]) begin
            run_txn(tbl[i], obs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL byte_merge[%0d]: got ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h, expected ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h",
                         i, obs.ack_cycle, obs.ack_next, obs.cs_cycles, obs.we_cycles, obs.rd_data, obs.word,
                         exp.ack_cycle, exp.ack_next, exp.cs_cycles, exp.we_cycles, exp.rd_data, exp.word);
            end
        end
    endtask

    task automatic test_empty_and_priority();
        stim_t tbl[2];
        result_t obs, exp;
        int acks;
        tbl[0] = '{rd: 1'b0, wr: 1'b1, be: 2'b00, addr: 32'h0000_0200, data: 16'h9999};
        tbl[1] = '{rd: 1'b1, wr: 1'b1, be: 2'b11, addr: 32'h0000_0300, data: 16'h5555};
        foreach (tbl[i]) begin
            run_txn(tbl[i], obs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL empty_prio[%0d]: got ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h, expected ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h",
                         i, obs.ack_cycle, obs.ack_next, obs.cs_cycles, obs.we_cycles, obs.rd_data, obs.word,
                         exp.ack_cycle, exp.ack_next, exp.cs_cycles, exp.we_cycles, exp.rd_data, exp.word);
            end
        end

        @(negedge clk);
        cpu_if.cpu_sel = 1'b0;
        cpu_if.cpu_rd_ena = 1'b1;
        cpu_if.cpu_wr_ena = 1'b1;
        cpu_if.cpu_byte_ena = 2'b11;
        cs_low_cnt = 0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_if.cpu_data_ack) acks++;
        end
        cpu_if.cpu_rd_ena = 1'b0;
        cpu_if.cpu_wr_ena = 1'b0;
        n_checks++;
        if (acks != 0 || cs_low_cnt != 0) begin
            n_fail++;
            $display("[TB] FAIL sel_ignored: got acks=%0d cs_low=%0d, expected 0 and 0", acks, cs_low_cnt);
        end
    endtask

    task automatic test_reset_abort();
        stim_t s;
        result_t obs, exp;
        int acks;
        preload(18'h00300, 16'hBEEF);
        @(negedge clk);
        cpu_if.cpu_sel = 1'b1;
        cpu_if.cpu_wr_ena = 1'b1;
        cpu_if.cpu_byte_ena = 2'b11;
        cpu_if.cpu_address = 32'h0000_0400;
        cpu_if.cpu_wr_data = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sram_we_n !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_we_low: got we_n=%b, expected 0", sram_we_n);
        end
        rst = 1'b1;
        cpu_if.cpu_sel = 1'b0;
        cpu_if.cpu_wr_ena = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_rd = 16'h0000;
        n_checks++;
        if ({sram_cs_n, sram_oe_n, sram_we_n, sram_data_oe, cpu_if.cpu_data_ack} !== 5'b11100) begin
            n_fail++;
            $display("[TB] FAIL abort_strobes: got cs/oe/we/doe/ack=%b, expected 11100",
                     {sram_cs_n, sram_oe_n, sram_we_n, sram_data_oe, cpu_if.cpu_data_ack});
        end
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_if.cpu_data_ack) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_ack: got %0d acks, expected 0", acks);
        end
        s = '{rd: 1'b1, wr: 1'b0, be: 2'b11, addr: 32'h0000_0600, data: 16'h0000};
        run_txn(s, obs);
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL abort_read: got ack@%0d rd=%h cs=%0d, expected ack@%0d rd=%h cs=%0d",
                     obs.ack_cycle, obs.rd_data, obs.cs_cycles, exp.ack_cycle, exp.rd_data, exp.cs_cycles);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        result_t obs, exp;
        logic [31:0] r, r2;
        for (int i = 0; i < 4; i++) preload(18'h00010 + 18'(i), 16'(32'h3C00 + i * 32'h0111));
        for (int i = 0; i < 12; i++) begin
            r = $urandom();
            r2 = $urandom();
            s.wr = r[7];
            s.rd = r[6] | ~r[7];
            s.be = r[9:8];
            s.data = r[31:16];
            s.addr = {r2[31:19], 16'h0001, r[5:4], r2[0]};
            run_txn(s, obs);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL b2b[%0d] rd=%b wr=%b be=%b: got ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h, expected ack@%0d ackNext=%0b cs=%0d we=%0d rd=%h word=%h",
                         i, s.rd, s.wr, s.be, obs.ack_cycle, obs.ack_next, obs.cs_cycles, obs.we_cycles, obs.rd_data, obs.word,
                         exp.ack_cycle, exp.ack_next, exp.cs_cycles, exp.we_cycles, exp.rd_data, exp.word);
            end
        end
    endtask

    task automatic test_bus_contention();
        n_checks++;
        if (contention_cnt != 0) begin
            n_fail++;
            $display("[TB] FAIL bus_contention: got %0d cycles with data_oe high and oe_n low, expected 0", contention_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        model_rd = 16'h0000;
        cpu_if.cpu_sel = 1'b0;
        cpu_if.cpu_rd_ena = 1'b0;
        cpu_if.cpu_wr_ena = 1'b0;
        cpu_if.cpu_byte_ena = 2'b00;
        cpu_if.cpu_address = '0;
        cpu_if.cpu_wr_data = '0;
        test_reset();
        test_word_write_read();
        test_byte_merge();
        test_empty_and_priority();
        test_reset_abort();
        test_back_to_back();
        test_bus_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
